// File: rtl/product_term_config_loader.sv
// Serial loader for one macrocell's product-term enable masks; commits all masks atomically.
// Last bit accepted at edge E -> masks and done visible after E+1; config_ready is high only while shifting.
module product_term_config_loader #(
   parameter int num_input_signals = 88,
   parameter int num_product_terms = 5,
   parameter int stall_limit       = 0
) (
   input  logic                                         clock,
   input  logic                                         reset_n,
   input  logic                                         start,
   input  logic                                         abort,
   input  logic                                         config_valid,
   input  logic                                         config_bit,
   output logic                                         config_ready,
   output logic [num_product_terms*num_input_signals-1:0] product_term_enable,
   output logic                                         busy,
   output logic                                         done,
   output logic                                         error
);

   localparam int total   = num_product_terms * num_input_signals;
   localparam int cnt_w   = $clog2(total + 1);
   localparam int stall_w = (stall_limit > 0) ? $clog2(stall_limit + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [total-1:0]   shadow;
   logic [cnt_w-1:0]   bit_count;
   logic [stall_w-1:0] stall_count;

   logic transfer;
   logic last_bit;
   logic stall_hit;
   logic load_start;
   logic shift_en;
   logic commit_en;
   logic busy_nxt;
   logic done_nxt;
   logic error_nxt;

   assign config_ready = (state == SHIFT);
   assign transfer     = config_valid & config_ready;
   assign last_bit     = (bit_count == cnt_w'(total - 1));

   // Stall detection fires on the idle cycle that would bring the count up to the limit.
   generate
      if (stall_limit > 0) begin : g_stall
         assign stall_hit = (state == SHIFT) & ~config_valid &
                            (stall_count == stall_w'(stall_limit - 1));
      end else begin : g_no_stall
         assign stall_hit = 1'b0;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (abort || stall_hit)      state_nxt = IDLE;
            else if (transfer && last_bit) state_nxt = COMMIT;
         end
         COMMIT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      load_start = (state == IDLE) & start;
      shift_en   = transfer & ~abort;
      commit_en  = (state == COMMIT);
      busy_nxt   = (state_nxt != IDLE);
      done_nxt   = commit_en;
      error_nxt  = error;
      if (load_start) error_nxt = 1'b0;
      else if ((state == SHIFT) && (abort || stall_hit)) error_nxt = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shadow              <= '0;
         bit_count           <= '0;
         stall_count         <= '0;
         product_term_enable <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         error               <= 1'b0;
      end else begin
         busy  <= busy_nxt;
         done  <= done_nxt;
         error <= error_nxt;
         if (load_start) begin
            shadow      <= '0;
            bit_count   <= '0;
            stall_count <= '0;
         end else if (shift_en) begin
            for (int i = 0; i < total; i++) begin
               if (bit_count == cnt_w'(i)) shadow[i] <= config_bit;
            end
            bit_count   <= bit_count + cnt_w'(1);
            stall_count <= '0;
         end else if ((stall_limit > 0) && (state == SHIFT) && !config_valid) begin
            stall_count <= stall_count + stall_w'(1);
         end
         if (commit_en) product_term_enable <= shadow;
      end
   end

endmodule
